// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO.
//   UART_DATA_BITS : default character width (matches the receiver)
//   UART_DEPTH     : default FIFO entry count (power of two, >= 2)
//   rx_entry_t     : one stored entry {frame_err, parity_err, data}
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DEPTH     = 16;

  typedef struct packed {
    logic                      frame_err;
    logic                      parity_err;
    logic [UART_DATA_BITS-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write entry
//   raddr : read index
//   rdata : read entry, combinational from raddr
// Synchronous write, asynchronous read, no reset. Contents are don't-care
// until written; the owner masks outputs while the FIFO is empty.
module uart_fifo_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO buffering characters from a UART receiver.
//   clk, reset_n          : clock, async active-low reset
//   rx_data, data_ready   : character and single-cycle push strobe
//   parity_err, frame_err : error flags captured with the character
//   rd_valid, rd_ready    : head entry handshake (pop when both high)
//   rd_data, rd_parity_err, rd_frame_err : head entry, 0 while empty
//   count, full, empty    : occupancy, derived from the pointers only
//   overrun, overrun_clr  : sticky drop flag and its clear
// DEPTH must be a power of two and at least 2.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = UART_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_BITS-1:0]   rx_data,
  input  logic                   data_ready,
  input  logic                   parity_err,
  input  logic                   frame_err,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   rd_parity_err,
  output logic                   rd_frame_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int WIDTH = DATA_BITS + 2;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] head;
  logic             push, pop, drop;

  // Extra MSB on each pointer is the wrap bit: equal pointers mean empty,
  // equal indices with differing wrap bits mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  // No bypass: a push into an empty FIFO becomes visible one cycle later.
  assign pop  = !empty && rd_ready;
  // At full, a same-edge pop frees the slot the push lands in.
  assign push = data_ready && (!full || pop);
  assign drop = data_ready && full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // A drop on the same edge wins over the clear.
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({frame_err, parity_err, rx_data}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  // Storage is unreset, so mask the head while empty.
  assign rd_valid      = !empty;
  assign rd_data       = empty ? '0 : head[DATA_BITS-1:0];
  assign rd_parity_err = !empty && head[DATA_BITS];
  assign rd_frame_err  = !empty && head[DATA_BITS+1];

endmodule
